instr_window_fetch: RTL and testbench

- Instruction prefetch queue feeding the pipeline control FSM and decode stage.
- Fetches sequential 8-bit instructions from instruction memory into a small FIFO.
- Presents a three-deep look-ahead window (instr, next_instr, next_next_instr) so hazard logic can inspect upcoming opcodes.
- Consumes the controller's advance and redirect commands and is the responder side of the PC-write/IR-load interface.

---
 rtl/instr_pkg.sv | 21 ++
 rtl/instr_window_fetch_fifo.sv | 85 ++++++++
 rtl/instr_window_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_window_fetch.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared instruction-fetch definitions.
// Holds the default address width, the bubble encoding driven on empty
// window slots, and the low-nibble opcode classes that both this fetch
// block and the pipeline control FSM decode.
package instr_pkg;

  localparam int ADDR_W_DEF = 8;

  // Matches no hazard, branch or stop decode, so an empty slot is inert.
  localparam logic [7:0] BUBBLE_INSTR_DEF = 8'h0A;

  localparam logic [3:0] OP_STOP = 4'b0001;
  localparam logic [3:0] OP_BR0  = 4'b0101;
  localparam logic [3:0] OP_BR1  = 4'b1001;
  localparam logic [3:0] OP_BR2  = 4'b1101;

  function automatic logic is_stop(input logic [7:0] ins);
    return ins[3:0] == OP_STOP;
  endfunction

endpackage

// File: rtl/instr_window_fetch_fifo.sv
// instr_fifo_tagged: DEPTH-entry circular buffer of {pc, instr}.
// Ports:
//   clock, reset        clock / async active-high reset
//   flush_i             empty the buffer (wins over push/pop)
//   push_i, push_pc_i, push_instr_i   write one tagged entry at the tail
//   pop_i               drop the head; caller guarantees non-empty
//   peek_instr_o[k]     instruction at head+k, k=0..2 (raw, unqualified)
//   head_pc_o           PC tag of the head entry
//   count_o             occupied entries
module instr_fifo_tagged
  import instr_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [ADDR_W-1:0]        push_pc_i,
  input  logic [7:0]               push_instr_i,
  input  logic                     pop_i,
  output logic [2:0][7:0]          peek_instr_o,
  output logic [ADDR_W-1:0]        head_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]        instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; validity comes from cnt_q.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) begin
      instr_mem[wr_q] <= push_instr_i;
      pc_mem[wr_q]    <= push_pc_i;
    end
  end

  // DEPTH is a power of two, so PW-bit addition wraps the ring for free.
  for (genvar k = 0; k < 3; k++) begin : g_peek
    logic [PW-1:0] idx;
    assign idx             = rd_q + PW'(k);
    assign peek_instr_o[k] = instr_mem[idx];
  end

  assign head_pc_o = pc_mem[rd_q];
  assign count_o   = cnt_q;

endmodule

// File: rtl/instr_window_fetch.sv
// instr_window_fetch: sequential instruction prefetch queue with a
// three-deep look-ahead window for hazard/decode logic.
// Optional feature macro: INSTR_WINDOW_STOP_HALT_EN -- when defined, pushing
// a stop opcode halts further fetching until redirect or reset.
// Ports:
//   clock, reset              clock / async active-high reset
//   advance                   retire head (ignored when empty)
//   redirect, redirect_pc     flush queue and refetch from redirect_pc
//   mem_req, mem_addr         read request; data returns one cycle later
//   mem_rdata                 read data
//   instr/next_instr/next_next_instr  window, BUBBLE on empty slots
//   win_valid                 per-slot valid, bit0 = instr
//   instr_pc                  head PC, or next expected PC when empty
//   queue_count               occupied entries
module instr_window_fetch
  import instr_pkg::*;
#(
  parameter int               ADDR_W       = ADDR_W_DEF,
  parameter int               DEPTH        = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [7:0]       BUBBLE_INSTR = BUBBLE_INSTR_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   advance,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [7:0]             mem_rdata,
  output logic [7:0]             instr,
  output logic [7:0]             next_instr,
  output logic [7:0]             next_next_instr,
  output logic [2:0]             win_valid,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              epoch_q, epoch_d;
  logic              req_epoch_q, req_epoch_d;

  logic [2:0][7:0]   peek;
  logic [ADDR_W-1:0] head_pc;
  logic [CW-1:0]     cnt;
  logic              rsp_ok, push, pop, stop_block;
  logic [CW:0]       occ;

  // A response counts only if it belongs to the current epoch; redirect in
  // the arrival cycle drops it too, since the queue is being flushed.
  assign rsp_ok = inflight_q && (req_epoch_q == epoch_q);
  assign push   = rsp_ok && !redirect;
  assign pop    = advance && (cnt != '0) && !redirect;

  // Occupancy after this cycle's retire, counting the slot reserved by an
  // outstanding read, so the response always has room.
  assign occ = {1'b0, cnt} + (CW+1)'(inflight_q)
             - (CW+1)'(advance && (cnt != '0));

`ifdef INSTR_WINDOW_STOP_HALT_EN
  logic halted_q, halted_d;
  // Block the request issued alongside the stop push as well, so nothing
  // past the stop is fetched.
  assign stop_block = halted_q || (push && is_stop(mem_rdata));
  always_comb begin
    halted_d = halted_q;
    if (redirect)                          halted_d = 1'b0;
    else if (push && is_stop(mem_rdata))   halted_d = 1'b1;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end
`else
  assign stop_block = 1'b0;
`endif

  assign mem_req  = !reset && !redirect && !stop_block && (occ < (CW+1)'(DEPTH));
  assign mem_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    inflight_d  = mem_req;
    epoch_d     = epoch_q;
    req_epoch_d = req_epoch_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      epoch_d    = ~epoch_q;
      inflight_d = 1'b0;
    end else if (mem_req) begin
      fetch_pc_d  = fetch_pc_q + 1'b1;
      req_pc_d    = fetch_pc_q;
      req_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      inflight_q  <= 1'b0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
    end
  end

  instr_fifo_tagged #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .flush_i      (redirect),
    .push_i       (push),
    .push_pc_i    (req_pc_q),
    .push_instr_i (mem_rdata),
    .pop_i        (pop),
    .peek_instr_o (peek),
    .head_pc_o    (head_pc),
    .count_o      (cnt)
  );

  for (genvar i = 0; i < 3; i++) begin : g_win
    assign win_valid[i] = cnt > CW'(i);
  end

  assign instr           = win_valid[0] ? peek[0] : BUBBLE_INSTR;
  assign next_instr      = win_valid[1] ? peek[1] : BUBBLE_INSTR;
  assign next_next_instr = win_valid[2] ? peek[2] : BUBBLE_INSTR;

  // Empty queue: show the address the next pushed entry will carry.
  assign instr_pc    = win_valid[0] ? head_pc : (fetch_pc_q - ADDR_W'(inflight_q));
  assign queue_count = cnt;

endmodule

// File: tb/tb_instr_window_fetch.sv
module tb_instr_window_fetch;
  logic       clock = 1'b0;
  logic       reset;
  logic       advance, redirect;
  logic [7:0] redirect_pc;
  logic       mem_req;
  logic [7:0] mem_addr, mem_rdata;
  logic [7:0] instr, next_instr, next_next_instr;
  logic [2:0] win_valid;
  logic [7:0] instr_pc;
  logic [2:0] queue_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];

  typedef struct { logic [7:0] pc; logic [7:0] ins; } ent_t;
  ent_t sb[$];
  ent_t e;

  always #5 clock = ~clock;

  // One-cycle-latency memory, always ready.
  always @(posedge clock) if (mem_req) mem_rdata <= mem[mem_addr];

  instr_window_fetch dut (
    .clock(clock), .reset(reset), .advance(advance), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .instr(instr), .next_instr(next_instr),
    .next_next_instr(next_next_instr), .win_valid(win_valid),
    .instr_pc(instr_pc), .queue_count(queue_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic sb_fill(input logic [7:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) begin
      e.pc  = start + 8'(i);
      e.ins = mem[e.pc];
      sb.push_back(e);
    end
  endtask

  // Retire n instructions back to back, checking each against the scoreboard.
  task automatic retire(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      advance = 1'b1;
      #1;
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(win_valid[0]), 32'd1);
      chk({tag, "_instr"}, 32'(instr), 32'(e.ins));
      chk({tag, "_pc"},    32'(instr_pc), 32'(e.pc));
      tick();
    end
    advance = 1'b0;
  endtask

  task automatic do_redirect(input logic [7:0] pc);
    redirect = 1'b1;
    redirect_pc = pc;
    #1;
    chk("redir_req", 32'(mem_req), 32'd0);
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 'h10);
    reset = 1'b1; advance = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #3;
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_valid", 32'(win_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'h0A);
    chk("rst_nxt",   32'(next_instr), 32'h0A);
    chk("rst_nnxt",  32'(next_next_instr), 32'h0A);
    chk("rst_pc",    32'(instr_pc), 32'h00);
    chk("rst_cnt",   32'(queue_count), 32'd0);
    tick();
    reset = 1'b0;

    // Fill with no retire; cycle 0 also advances on the empty queue.
    for (int c = 0; c < 7; c++) begin
      advance = (c == 0);
      #1;
      chk("fill_req", 32'(mem_req), (c < 4) ? 32'd1 : 32'd0);
      if (c < 4) chk("fill_addr", 32'(mem_addr), 32'(c));
      chk("fill_cnt", 32'(queue_count), (c <= 1) ? 32'd0 : ((c - 1 > 4) ? 32'd4 : 32'(c - 1)));
      if (c == 0) chk("empty_adv_instr", 32'(instr), 32'h0A);
      tick();
    end
    advance = 1'b0;
    #1;
    chk("full_instr", 32'(instr), 32'h10);
    chk("full_nxt",   32'(next_instr), 32'h11);
    chk("full_nnxt",  32'(next_next_instr), 32'h12);
    chk("full_valid", 32'(win_valid), 32'b111);
    chk("full_cnt",   32'(queue_count), 32'd4);

    // Streaming retire: one per cycle, no bubbles, request stays up.
    sb_fill(8'h00, 16);
    for (int i = 0; i < 8; i++) begin
      advance = 1'b1;
      #1;
      e = sb.pop_front();
      chk("strm_instr", 32'(instr), 32'(e.ins));
      chk("strm_pc",    32'(instr_pc), 32'(e.pc));
      chk("strm_req",   32'(mem_req), 32'd1);
      tick();
    end
    advance = 1'b0;

    // Redirect to 0x04, then redirect to 0x40 while the 0x05 read returns.
    do_redirect(8'h04);
    #1;
    chk("r1_addr", 32'(mem_addr), 32'h04);
    chk("r1_req",  32'(mem_req), 32'd1);
    tick();
    #1;
    chk("r2_addr", 32'(mem_addr), 32'h05);
    tick();
    #1;
    chk("r3_instr", 32'(instr), 32'h14);
    chk("r3_pc",    32'(instr_pc), 32'h04);
    do_redirect(8'h40);
    #1;
    chk("sq1_cnt",  32'(queue_count), 32'd0);
    chk("sq1_addr", 32'(mem_addr), 32'h40);
    chk("sq1_req",  32'(mem_req), 32'd1);
    tick();
    #1;
    chk("sq2_cnt",  32'(queue_count), 32'd0);
    chk("sq2_pc",   32'(instr_pc), 32'h40);
    tick();
    #1;
    chk("tgt_cnt", 32'(queue_count), 32'd1);
    sb_fill(8'h40, 12);
    retire("tgt", 6);

    // Address wrap at 2^ADDR_W.
    do_redirect(8'hFE);
    #1; chk("wrap_a0", 32'(mem_addr), 32'hFE); tick();
    #1; chk("wrap_a1", 32'(mem_addr), 32'hFF); tick();
    #1; chk("wrap_a2", 32'(mem_addr), 32'h00);
    sb_fill(8'hFE, 8);
    retire("wrap", 4);

    // Stop opcode at address 2.
    mem[2] = 8'h01;
    do_redirect(8'h00);
    tick(); tick(); tick();
    #1;
    chk("stop_cnt", 32'(queue_count), 32'd2);
`ifdef INSTR_WINDOW_STOP_HALT_EN
    chk("stop_req", 32'(mem_req), 32'd0);
`else
    chk("stop_req",  32'(mem_req), 32'd1);
    chk("stop_addr", 32'(mem_addr), 32'h03);
`endif
    tick();
    #1;
    chk("stop_win0", 32'(instr), 32'h10);
    chk("stop_win2", 32'(next_next_instr), 32'h01);
    do_redirect(8'h08);
    #1;
    chk("resume_req",  32'(mem_req), 32'd1);
    chk("resume_addr", 32'(mem_addr), 32'h08);
    tick();

    // Reset while the 0x08 read is outstanding.
    #1;
    reset = 1'b1;
    #1;
    chk("mrst_cnt", 32'(queue_count), 32'd0);
    chk("mrst_req", 32'(mem_req), 32'd0);
    chk("mrst_pc",  32'(instr_pc), 32'h00);
    tick();
    reset = 1'b0;
    #1;
    chk("post_addr", 32'(mem_addr), 32'h00);
    chk("post_req",  32'(mem_req), 32'd1);
    tick();
    #1;
    chk("post_cnt0", 32'(queue_count), 32'd0);
    tick();
    #1;
    chk("post_instr", 32'(instr), 32'h10);
    chk("post_pc",    32'(instr_pc), 32'h00);
    chk("post_cnt1",  32'(queue_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
